// File: rtl/branch_cmp_unit_pkg.sv
// Shared constants for the branch resolution unit: compare op codes,
// 2-bit PHT counter encodings and the saturating counter update.
package branch_cmp_unit_pkg;

  localparam logic [7:0] CMP_EQ  = 8'h00;
  localparam logic [7:0] CMP_NE  = 8'h01;
  localparam logic [7:0] CMP_LEZ = 8'h02;
  localparam logic [7:0] CMP_GTZ = 8'h03;
  localparam logic [7:0] CMP_LTZ = 8'h04;
  localparam logic [7:0] CMP_GEZ = 8'h05;
  localparam logic [7:0] CMP_LT  = 8'h06;
  localparam logic [7:0] CMP_LTU = 8'h07;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // Move one step toward the resolved direction, saturating at SNT/ST.
  function automatic ctr_e ctr_update(input ctr_e cur, input logic taken);
    ctr_e nxt;
    nxt = cur;
    case (cur)
      SNT: nxt = taken ? WNT : SNT;
      WNT: nxt = taken ? WT  : SNT;
      WT:  nxt = taken ? ST  : WNT;
      ST:  nxt = taken ? ST  : WT;
      default: nxt = WNT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/branch_cmp_core.sv
// Combinational branch condition evaluator on WIDTH-bit operands.
// Unknown op codes resolve to not-taken.
module branch_cmp_core
  import branch_cmp_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [7:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             taken_o
);

  logic src1_neg;
  logic src1_zero;

  assign src1_neg  = src1_i[WIDTH-1];
  assign src1_zero = (src1_i == '0);

  // Select the condition named by op_i; everything else is not-taken.
  always_comb begin
    taken_o = 1'b0;
    case (op_i)
      CMP_EQ:  taken_o = (src1_i == src2_i);
      CMP_NE:  taken_o = (src1_i != src2_i);
      CMP_LEZ: taken_o = src1_neg | src1_zero;
      CMP_GTZ: taken_o = ~src1_neg & ~src1_zero;
      CMP_LTZ: taken_o = src1_neg;
      CMP_GEZ: taken_o = ~src1_neg;
      CMP_LT:  taken_o = ($signed(src1_i) < $signed(src2_i));
      CMP_LTU: taken_o = (src1_i < src2_i);
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_cmp_unit.sv
// Branch resolution unit: registered compare result with stall/flush,
// a PHT of 2-bit counters for fetch prediction, and a saturating
// mispredict counter.
//
// Handshake: a branch is consumed on a clk edge when in_valid=1, stall=0
// and flush=0; there is no ready output, so the producer must hold the
// branch while stall=1. flush discards the presented branch and clears
// the output stage, taking priority over stall; reset beats both.
module branch_cmp_unit
  import branch_cmp_unit_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int PHT_DEPTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      lookup_pc,
  output logic             lookup_taken,
  input  logic             in_valid,
  input  logic [7:0]       cmp_op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [31:0]      br_pc,
  input  logic             br_pred,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic             out_taken,
  output logic             out_mispredict,
  output logic [31:0]      mispredict_count
);

  localparam int IDX_W = $clog2(PHT_DEPTH);

  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] br_idx;
  logic             cmp_taken;
  logic             mispredict;
  logic             capture_en;
  logic             pht_we;

  ctr_e             pht_q [PHT_DEPTH];
  ctr_e             pht_entry_d;

  logic             out_valid_q, out_valid_d;
  logic             out_taken_q, out_taken_d;
  logic             out_mispredict_q, out_mispredict_d;
  logic [31:0]      count_q, count_d;

  // PC bits outside the word-aligned index field do not select an entry.
  logic             unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0],
                            br_pc[31:IDX_W+2], br_pc[1:0]};

  assign lookup_idx = lookup_pc[IDX_W+1:2];
  assign br_idx     = br_pc[IDX_W+1:2];

  // Reads the registered table, so a same-cycle update is not visible yet.
  assign lookup_taken = pht_q[lookup_idx][1];

  branch_cmp_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .op_i   (cmp_op),
    .src1_i (src1),
    .src2_i (src2),
    .taken_o(cmp_taken)
  );

  assign mispredict  = (cmp_taken != br_pred);
  assign capture_en  = ~flush & ~stall;
  assign pht_we      = capture_en & in_valid;
  assign pht_entry_d = ctr_update(pht_q[br_idx], cmp_taken);

  // Next state of the output stage and mispredict counter.
  always_comb begin
    out_valid_d      = out_valid_q;
    out_taken_d      = out_taken_q;
    out_mispredict_d = out_mispredict_q;
    count_d          = count_q;
    if (flush) begin
      out_valid_d      = 1'b0;
      out_taken_d      = 1'b0;
      out_mispredict_d = 1'b0;
    end else if (!stall) begin
      out_valid_d      = in_valid;
      out_taken_d      = in_valid & cmp_taken;
      out_mispredict_d = in_valid & mispredict;
      if (in_valid && mispredict && (count_q != 32'hFFFF_FFFF)) begin
        count_d = count_q + 32'd1;
      end
    end
  end

  // Output stage and counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q      <= 1'b0;
      out_taken_q      <= 1'b0;
      out_mispredict_q <= 1'b0;
      count_q          <= 32'd0;
    end else begin
      out_valid_q      <= out_valid_d;
      out_taken_q      <= out_taken_d;
      out_mispredict_q <= out_mispredict_d;
      count_q          <= count_d;
    end
  end

  // PHT: all entries weakly not-taken after reset, one entry trained per capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < PHT_DEPTH; i++) begin
        pht_q[i] <= WNT;
      end
    end else if (pht_we) begin
      pht_q[br_idx] <= pht_entry_d;
    end
  end

  assign out_valid        = out_valid_q;
  assign out_taken        = out_taken_q;
  assign out_mispredict   = out_mispredict_q;
  assign mispredict_count = count_q;

endmodule

// File: tb/tb_branch_cmp_unit.sv
// Directed bench for branch_cmp_unit with hand-computed expectations.
module tb_branch_cmp_unit;

  logic        clk;
  logic        reset;
  logic [31:0] lookup_pc;
  logic        lookup_taken;
  logic        in_valid;
  logic [7:0]  cmp_op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] br_pc;
  logic        br_pred;
  logic        stall;
  logic        flush;
  logic        out_valid;
  logic        out_taken;
  logic        out_mispredict;
  logic [31:0] mispredict_count;

  int          checks;
  int          errors;
  logic [31:0] exp_cnt;

  branch_cmp_unit #(
    .WIDTH(32),
    .PHT_DEPTH(64)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .lookup_pc       (lookup_pc),
    .lookup_taken    (lookup_taken),
    .in_valid        (in_valid),
    .cmp_op          (cmp_op),
    .src1            (src1),
    .src2            (src2),
    .br_pc           (br_pc),
    .br_pred         (br_pred),
    .stall           (stall),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_taken       (out_taken),
    .out_mispredict  (out_mispredict),
    .mispredict_count(mispredict_count)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic t, input logic m);
    check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    check({tag, ".taken"}, {31'd0, out_taken}, {31'd0, t});
    check({tag, ".mispredict"}, {31'd0, out_mispredict}, {31'd0, m});
    check({tag, ".count"}, mispredict_count, exp_cnt);
  endtask

  task automatic check_lookup(input string tag, input logic [31:0] pc, input logic exp);
    lookup_pc = pc;
    #1;
    check(tag, {31'd0, lookup_taken}, {31'd0, exp});
  endtask

  // driver: present one branch for a single capture edge, then check result
  task automatic resolve(input string tag, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] pc, input logic pred,
                         input logic exp_taken);
    cmp_op   = op;
    src1     = a;
    src2     = b;
    br_pc    = pc;
    br_pred  = pred;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    if (exp_taken != pred && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
    check_out(tag, 1'b1, exp_taken, exp_taken != pred);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_cnt   = 32'd0;
    reset     = 1'b0;
    lookup_pc = 32'd0;
    in_valid  = 1'b0;
    cmp_op    = 8'h00;
    src1      = 32'd0;
    src2      = 32'd0;
    br_pc     = 32'd0;
    br_pred   = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;

    // reset for one cycle
    tick();
    reset = 1'b1;
    check_out("reset", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      check_lookup("reset.lookup", 32'h3000 + 32'(i * 4), 1'b0);
    end

    // first resolve: EQ taken against a not-taken prediction
    lookup_pc = 32'h3008;
    cmp_op = 8'h00; src1 = 32'h1234; src2 = 32'h1234; br_pc = 32'h3008;
    br_pred = 1'b0; in_valid = 1'b1;
    #1;
    check("rdw.pre_update", {31'd0, lookup_taken}, 32'd0);
    tick();
    in_valid = 1'b0;
    exp_cnt = 32'd1;
    check_out("eq", 1'b1, 1'b1, 1'b1);
    check_lookup("eq.lookup", 32'h3008, 1'b1);

    // idle cycle clears the output stage
    tick();
    check_out("idle", 1'b0, 1'b0, 1'b0);

    // signedness and op decode
    resolve("lt",   8'h06, 32'hFFFF_FFFF, 32'd1, 32'h3040, 1'b1, 1'b1);
    resolve("ltu",  8'h07, 32'hFFFF_FFFF, 32'd1, 32'h3040, 1'b1, 1'b0);
    resolve("gtz",  8'h03, 32'h8000_0000, 32'd0, 32'h3040, 1'b0, 1'b0);
    resolve("unk",  8'h5A, 32'd0, 32'd0, 32'h3040, 1'b0, 1'b0);
    resolve("lez",  8'h02, 32'd0, 32'd9, 32'h3040, 1'b0, 1'b1);
    resolve("gez",  8'h05, 32'h7FFF_FFFF, 32'd0, 32'h3040, 1'b1, 1'b1);
    resolve("ltz",  8'h04, 32'h8000_0000, 32'd0, 32'h3040, 1'b1, 1'b1);
    resolve("ne",   8'h01, 32'd1, 32'd2, 32'h3040, 1'b0, 1'b1);
    resolve("eq_n", 8'h00, 32'd1, 32'd2, 32'h3040, 1'b0, 1'b0);

    // saturation at 0x3010: WNT -> WT -> ST -> ST -> ST
    for (int i = 0; i < 4; i++) begin
      resolve("sat.t", 8'h00, 32'd0, 32'd0, 32'h3010, 1'b1, 1'b1);
    end
    check_lookup("sat.st", 32'h3010, 1'b1);
    resolve("sat.n1", 8'h01, 32'd0, 32'd0, 32'h3010, 1'b1, 1'b0);
    check_lookup("sat.wt", 32'h3010, 1'b1);
    resolve("sat.n2", 8'h01, 32'd0, 32'd0, 32'h3010, 1'b1, 1'b0);
    check_lookup("sat.wnt", 32'h3010, 1'b0);

    // stall for 3 cycles with a mispredicting branch presented
    cmp_op = 8'h00; src1 = 32'd5; src2 = 32'd5; br_pc = 32'h3018; br_pred = 1'b0;
    in_valid = 1'b1;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("stall", 1'b1, 1'b0, 1'b1);
      check_lookup("stall.pht", 32'h3018, 1'b0);
    end
    stall = 1'b0;
    tick();
    in_valid = 1'b0;
    exp_cnt = exp_cnt + 32'd1;
    check_out("release", 1'b1, 1'b1, 1'b1);
    check_lookup("release.pht", 32'h3018, 1'b1);

    // flush with stall and a mispredicting branch
    cmp_op = 8'h00; src1 = 32'd7; src2 = 32'd7; br_pc = 32'h3028; br_pred = 1'b0;
    in_valid = 1'b1;
    stall = 1'b1;
    flush = 1'b1;
    tick();
    in_valid = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    check_out("flush", 1'b0, 1'b0, 1'b0);
    check_lookup("flush.pht", 32'h3028, 1'b0);

    // reset mid-operation discards the in-flight branch and the training
    cmp_op = 8'h00; src1 = 32'd3; src2 = 32'd3; br_pc = 32'h3030; br_pred = 1'b0;
    in_valid = 1'b1;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    in_valid = 1'b0;
    exp_cnt = 32'd0;
    check_out("mid_reset", 1'b0, 1'b0, 1'b0);
    check_lookup("mid_reset.pht_a", 32'h3010, 1'b0);
    check_lookup("mid_reset.pht_b", 32'h3018, 1'b0);
    check_lookup("mid_reset.pht_c", 32'h3030, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_cmp_unit.md
Name: branch_cmp_unit

Overview:
- Parametrised branch resolution unit for the P7 pipeline; successor to the purely combinational D-stage comparator.
- Evaluates an extended set of branch conditions on WIDTH-bit operands and registers the result (1-cycle latency) with stall/flush control.
- Maintains a pattern history table (PHT) of 2-bit saturating counters. The table supplies a fetch-time prediction and flags mispredicts at resolve.
- Keeps a saturating mispredict performance counter.

Parameters:
- WIDTH, 32, operand width in bits.
- PHT_DEPTH, 64, number of PHT entries (power of two, >=2).
- IDX_W, $clog2(PHT_DEPTH), PHT index width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- lookup_pc  input  32  fetch-stage PC for prediction lookup.
- lookup_taken  output  1  predicted direction for lookup_pc (combinational).
- in_valid  input  1  a branch is presented for resolution this cycle.
- cmp_op  input  8  compare operation code.
- src1  input  WIDTH  first operand (forwarded value).
- src2  input  WIDTH  second operand (forwarded value).
- br_pc  input  32  PC of the resolving branch.
- br_pred  input  1  prediction made for this branch at fetch.
- stall  input  1  hold output stage; ignore inputs.
- flush  input  1  discard the presented branch and clear the output stage.
- out_valid  output  1  registered result valid.
- out_taken  output  1  registered branch outcome.
- out_mispredict  output  1  out_taken != captured br_pred.
- mispredict_count  output  32  saturating count of mispredicts.

Behaviour:
- Reset (reset==0 at a clk edge):
  - out_valid=0, out_taken=0, out_mispredict=0, mispredict_count=0.
  - All PHT entries set to 2'b01 (weakly not-taken).
  - Takes effect in a single cycle.
- Index: idx = pc[IDX_W+1:2] for both lookup_pc and br_pc (word-aligned).
- lookup_taken = PHT[idx(lookup_pc)][1], purely combinational.
- Compare functions, combinational, on WIDTH bits:
  - CMP_EQ: src1==src2
  - CMP_NE: src1!=src2
  - CMP_LEZ: signed src1<=0
  - CMP_GTZ: signed src1>0
  - CMP_LTZ: signed src1<0
  - CMP_GEZ: signed src1>=0
  - CMP_LT: signed src1<src2
  - CMP_LTU: unsigned src1<src2
  - Any other code yields 0 (not taken). No latches, no held value.
- Capture: at an edge with reset==1, flush==0, stall==0:
  - out_valid <= in_valid.
  - If in_valid: out_taken <= cmp result; out_mispredict <= (cmp result != br_pred).
  - If !in_valid: out_taken <= 0, out_mispredict <= 0.
  - Latency is exactly 1 cycle.
- PHT update happens on the same edge as capture, only when in_valid, !stall and !flush:
  - Taken: counter increments, saturating at 2'b11.
  - Not taken: counter decrements, saturating at 2'b00.
- Read-during-write: a same-cycle lookup of the index being updated returns the pre-update value.
- mispredict_count increments on each capture edge where in_valid and the result differs from br_pred. It saturates at 32'hFFFF_FFFF.
- stall==1 (flush==0): all outputs, the PHT and the counter hold; inputs are ignored.
- flush==1: out_valid, out_taken and out_mispredict clear next cycle. No PHT or counter update. flush has priority over stall.
- reset has priority over flush and stall. Reset mid-operation discards any in-flight result.

Decomposition:
- Shared constants file gains the 8-bit CMP_* codes:
  - CMP_EQ=8'h00, CMP_NE=8'h01, CMP_LEZ=8'h02, CMP_GTZ=8'h03, CMP_LTZ=8'h04, CMP_GEZ=8'h05, CMP_LT=8'h06, CMP_LTU=8'h07.
  - Also the counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
- One sub-module is natural: branch_cmp_core. It holds the combinational compare, parametrised by WIDTH, is instantiated once, and is reusable elsewhere.
- The PHT and output registers stay in the top module.

Test Plan:
- Reset with reset=0 for 1 cycle, then lookup_pc=0x3000..0x30FC -> lookup_taken=0 for all; out_valid=0; mispredict_count=0.
- in_valid=1, CMP_EQ, src1=src2=0x1234, br_pred=0, br_pc=0x3008 -> next cycle out_valid=1, out_taken=1, out_mispredict=1, mispredict_count=1. Lookup 0x3008 then returns 1 (WNT->WT).
- Signedness: CMP_LT with src1=0xFFFFFFFF, src2=1 -> taken. CMP_LTU with the same operands -> not taken. CMP_GTZ with src1=0x80000000 -> not taken. Unknown op 8'h5A -> out_taken=0.
- Saturation: 4 consecutive taken resolves at br_pc=0x3010 leave the counter at ST. One not-taken resolve -> lookup still 1. Two not-taken resolves -> lookup 0.
- stall=1 while in_valid=1 for 3 cycles -> outputs, PHT and counter unchanged. Release -> result appears 1 cycle later.
- flush=1 together with stall=1 and in_valid=1 (mispredicting) -> out_valid=0 next cycle; counter and PHT unchanged.
